// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and defaults for the data memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD
`define WORD 32
`endif

package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] C_FINISH_ADDR = 32'hFFFF_FFF0;

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
// ============================================================================
// Module      : dmem_lane
// Description : Byte-lane steering: store byte enables / shifted data and
//               load lane selection with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane
    import dmem_pkg::*;
#(
    parameter  int WORD = `WORD,
    localparam int WB   = WORD / 8,
    localparam int OFFW = $clog2(WB)
) (
    input  size_t             size,
    input  logic [OFFW-1:0]   offset,
    input  logic              uns,
    input  logic [WORD-1:0]   wdata,
    input  logic [WORD-1:0]   rword,
    output logic [WB-1:0]     be,
    output logic [WORD-1:0]   wdata_sh,
    output logic [WORD-1:0]   rdata_ext
);

    logic [OFFW-1:0] w_off_h;
    logic [WORD-1:0] w_rsh_b;
    logic [WORD-1:0] w_rsh_h;

    // Half accesses always use an even offset; word accesses ignore the offset.
    assign w_off_h = offset & ~OFFW'(1);
    assign w_rsh_b = rword >> {offset, 3'b000};
    assign w_rsh_h = rword >> {w_off_h, 3'b000};

    always_comb begin
        be        = '1;
        wdata_sh  = wdata;
        rdata_ext = rword;
        case (size)
            SZ_B: begin
                be        = WB'(1) << offset;
                wdata_sh  = WORD'(wdata[7:0]) << {offset, 3'b000};
                rdata_ext = uns ? WORD'(w_rsh_b[7:0])
                                : WORD'($signed(w_rsh_b[7:0]));
            end
            SZ_H: begin
                be        = WB'(2'b11) << w_off_h;
                wdata_sh  = WORD'(wdata[15:0]) << {w_off_h, 3'b000};
                rdata_ext = uns ? WORD'(w_rsh_h[15:0])
                                : WORD'($signed(w_rsh_h[15:0]));
            end
            default: begin
                be        = '1;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : Handshaked multi-cycle data memory controller with byte/half/
//               word accesses and a memory-mapped sticky finish register.
//               Define DMEM_ALIGN_CHECK_EN to report misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int              WORD        = `WORD,
    parameter int              DEPTH       = 1024,
    parameter int              LATENCY     = 1,
    parameter logic [WORD-1:0] FINISH_ADDR = WORD'(C_FINISH_ADDR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic            finish
);

    localparam int         WB    = WORD / 8;
    localparam int         OFFW  = $clog2(WB);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] C_LAT = 4'(LATENCY);

    logic [WORD-1:0] r_mem [DEPTH];

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_ready;
    logic            r_resp_valid;
    logic [WORD-1:0] r_resp_rdata;
    logic            r_finish;
    logic            r_write;
    size_t           r_size;
    logic            r_uns;
    logic [OFFW-1:0] r_off;
    logic            r_is_fin;
    logic            r_err;
    logic [WORD-1:0] r_rword;

    size_t           w_size;
    logic [OFFW-1:0] w_off;
    logic [AW-1:0]   w_idx;
    logic            w_accept;
    logic            w_is_fin;
    logic            w_mis;
    logic            w_we;
    size_t           w_lane_size;
    logic [OFFW-1:0] w_lane_off;
    logic [WB-1:0]   w_be;
    logic [WORD-1:0] w_wsh;
    logic [WORD-1:0] w_ld;

    always_comb begin
        case (req_size)
            2'd0:    w_size = SZ_B;
            2'd1:    w_size = SZ_H;
            default: w_size = SZ_W;
        endcase
    end

    assign w_off    = req_addr[OFFW-1:0];
    assign w_idx    = req_addr[OFFW +: AW];
    assign w_accept = req_valid && r_ready;
    assign w_is_fin = (req_addr == FINISH_ADDR);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = ((w_size == SZ_H) && w_off[0]) ||
                   ((w_size == SZ_W) && (w_off != '0));
`else
    assign w_mis = 1'b0;
`endif

    assign w_we = w_accept && req_write && !w_is_fin && !w_mis;

    // Store steering uses the live request in IDLE; load steering uses the latched one.
    assign w_lane_size = (r_state == IDLE) ? w_size : r_size;
    assign w_lane_off  = (r_state == IDLE) ? w_off  : r_off;

    dmem_lane #(
        .WORD (WORD)
    ) u_lane (
        .size      (w_lane_size),
        .offset    (w_lane_off),
        .uns       (r_uns),
        .wdata     (req_wdata),
        .rword     (r_rword),
        .be        (w_be),
        .wdata_sh  (w_wsh),
        .rdata_ext (w_ld)
    );

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < WB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wsh[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_finish     <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= SZ_W;
            r_uns        <= 1'b0;
            r_off        <= '0;
            r_is_fin     <= 1'b0;
            r_err        <= 1'b0;
            r_rword      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_write  <= req_write;
                        r_size   <= w_size;
                        r_uns    <= req_unsigned;
                        r_off    <= w_off;
                        r_is_fin <= w_is_fin;
                        r_err    <= w_mis;
                        r_rword  <= r_mem[w_idx];
                        if (LATENCY == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= C_LAT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b1;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                    if (r_write || r_err) begin
                        r_resp_rdata <= '0;
                    end else if (r_is_fin) begin
                        r_resp_rdata <= WORD'(r_finish);
                    end else begin
                        r_resp_rdata <= w_ld;
                    end
                    if (r_write && r_is_fin && !r_err) begin
                        r_finish <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_resp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_err <= 1'b0;
        end else if (r_state == RESP) begin
            r_resp_err <= r_err;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign finish     = r_finish;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed scoreboard bench for dmem_ctrl (LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        finish;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic fin_at_resp;
    logic mis_err;
    int   seen;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .WORD    (32),
        .DEPTH   (1024),
        .LATENCY (LAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .finish       (finish)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response pulse.
    task automatic xact(input string name, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "/ready_wait"}, 32'(n < 20), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hx;
        req_wdata = 32'hx;
        chk({name, "/ready_busy"}, 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "/latency"}, n, LAT + 1);
        fin_at_resp = finish;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk({name, "/rdata"}, resp_rdata, e.rdata);
        chk({name, "/err"}, 32'(resp_err), 32'(e.err));
        @(negedge clk);
        chk({name, "/pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis_err = 1'b1;
`else
        mis_err = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst/ready", 32'(req_ready), 32'd0);
        chk("rst/valid", 32'(resp_valid), 32'd0);
        chk("rst/rdata", resp_rdata, 32'd0);
        chk("rst/err", 32'(resp_err), 32'd0);
        chk("rst/finish", 32'(finish), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst/ready_after", 32'(req_ready), 32'd1);

        xact("st_w10",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0);
        xact("ld_w10",   0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
        xact("st_b13",   1, 2'd0, 0, 32'h13, 32'h00000080, 32'h0,        0);
        xact("ld_sb13",  0, 2'd0, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0);
        xact("ld_ub13",  0, 2'd0, 1, 32'h13, 32'h0,        32'h00000080, 0);
        xact("ld_w10b",  0, 2'd2, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0);
        xact("ld_sh12",  0, 2'd1, 0, 32'h12, 32'h0,        32'hFFFF80AD, 0);
        xact("ld_uh10",  0, 2'd1, 1, 32'h10, 32'h0,        32'h0000BEEF, 0);
        xact("st_w14",   1, 2'd2, 0, 32'h14, 32'h11223344, 32'h0,        0);
        xact("st_h16",   1, 2'd1, 0, 32'h16, 32'h0000AABB, 32'h0,        0);
        xact("ld_w14",   0, 2'd3, 0, 32'h14, 32'h0,        32'hAABB3344, 0);
        xact("ld_ub15",  0, 2'd0, 1, 32'h15, 32'h0,        32'h00000033, 0);

        xact("st_wrap",  1, 2'd2, 0, 32'h1000, 32'hCAFEF00D, 32'h0,      0);
        xact("ld_wrap",  0, 2'd2, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0);

        // The finish register aliases RAM word 0x3FC (byte 0xFF0).
        xact("st_ff0",   1, 2'd2, 0, 32'hFF0, 32'h5A5A5A5A, 32'h0,       0);
        chk("fin/before", 32'(finish), 32'd0);
        xact("st_fin",   1, 2'd2, 0, 32'hFFFF_FFF0, 32'h1, 32'h0,         0);
        chk("fin/at_resp", 32'(fin_at_resp), 32'd1);
        xact("ld_ff0",   0, 2'd2, 0, 32'hFF0, 32'h0,        32'h5A5A5A5A, 0);
        xact("ld_fin",   0, 2'd2, 0, 32'hFFFF_FFF0, 32'h0, 32'h1,         0);
        chk("fin/sticky", 32'(finish), 32'd1);

        xact("st_mis12", 1, 2'd2, 0, 32'h12, 32'h99887766, 32'h0, mis_err);
        xact("ld_after_mis", 0, 2'd2, 0, 32'h10, 32'h0,
             mis_err ? 32'h80ADBEEF : 32'h99887766, 0);

        // Reset while a load sits in WAIT: no response may escape.
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid/ready_busy", 32'(req_ready), 32'd0);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) rst = 1'b0;
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rstmid/no_resp", seen, 0);
        chk("rstmid/ready", 32'(req_ready), 32'd1);
        chk("rstmid/finish", 32'(finish), 32'd0);

        xact("ld_post_rst", 0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        chk("sb/empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
